// File: rtl/radix2_seq_divider_pkg.sv
// radix2_seq_divider_pkg: FSM state encoding shared by the divider files
package radix2_seq_divider_pkg;
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/radix2_seq_divider_div_nr_step.sv
// div_nr_step: one combinational non-restoring division step on an (N+1)-bit signed partial remainder
module div_nr_step #(
  parameter int N = 32
) (
  input  logic [N:0]   rem_in,
  input  logic [N-1:0] q_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_out,
  output logic [N-1:0] q_out
);
  logic [N:0] sh;
  // |rem_in| < divisor <= 2^(N-1), so dropping its top bit before the shift loses nothing
  assign sh      = {rem_in[N-1:0], q_in[N-1]};
  assign rem_out = rem_in[N] ? sh + {1'b0, divisor} : sh - {1'b0, divisor};
  assign q_out   = {q_in[N-2:0], ~rem_out[N]};
endmodule

// File: rtl/radix2_seq_divider.sv
// radix2_seq_divider: signed a/b truncating toward zero, one quotient bit per cycle, valid/ready I/O
module radix2_seq_divider
  import radix2_seq_divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         div_by_zero,
  output logic         overflow
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [N-1:0] a_r, b_r, q, dv, q_n, mag;
  logic [N:0] pr, pr_n;
  logic sign_q, sign_r, dz, ov;
  div_nr_step #(.N(N)) u_step (
    .rem_in (pr),
    .q_in   (q),
    .divisor(dv),
    .rem_out(pr_n),
    .q_out  (q_n)
  );
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // restore a negative final remainder; the result is below |b| so N bits suffice
  assign mag = pr[N-1:0] + (pr[N] ? dv : '0);
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? PREP : IDLE;
      PREP:    state_n = ITER;
      ITER:    state_n = (cnt == CW'(N - 1)) ? FIX : ITER;
      FIX:     state_n = DONE;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      q <= '0;
      dv <= '0;
      pr <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz <= 1'b0;
      ov <= 1'b0;
      quot <= '0;
      rem <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= b;
        end
        PREP: begin
          pr <= '0;
          q <= a_r[N-1] ? -a_r : a_r;
          dv <= b_r[N-1] ? -b_r : b_r;
          sign_q <= a_r[N-1] ^ b_r[N-1];
          sign_r <= a_r[N-1];
          dz <= b_r == '0;
          ov <= (a_r == MIN) && (b_r == '1);
          cnt <= '0;
        end
        ITER: begin
          pr <= pr_n;
          q <= q_n;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          quot <= dz ? '1 : ov ? MIN : sign_q ? -q : q;
          rem <= dz ? a_r : ov ? '0 : sign_r ? -mag : mag;
          div_by_zero <= dz;
          overflow <= ov;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_radix2_seq_divider.sv
// tb_radix2_seq_divider: vector table, corner sequences and random regression against a scoreboard
`timescale 1ns/1ps
module tb_radix2_seq_divider;
  localparam int N = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;
  localparam logic [31:0] MAX = 32'h7fff_ffff;
  typedef struct {
    logic [31:0] a, b, q, r;
    logic dz, ov;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, div_by_zero, overflow;
  logic [31:0] quot, rem;
  int checks = 0, errors = 0;
  vec_t sb[$];
  vec_t tbl[13];

  radix2_seq_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .quot(quot), .rem(rem),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [31:0] x, input logic [31:0] y);
    vec_t v;
    v.a = x; v.b = y; v.dz = 1'b0; v.ov = 1'b0;
    if (y == 0) begin
      v.q = '1; v.r = x; v.dz = 1'b1;
    end else if (x == MIN && y == '1) begin
      v.q = MIN; v.r = '0; v.ov = 1'b1;
    end else begin
      v.q = $signed(x) / $signed(y);
      v.r = $signed(x) % $signed(y);
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got quot %0h rem %0h with no operation pending", quot, rem);
      end else begin
        vec_t e;
        longint sa, sb_, sq, sr;
        e = sb.pop_front();
        chk("quot", {32'h0, quot}, {32'h0, e.q});
        chk("rem", {32'h0, rem}, {32'h0, e.r});
        chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, e.dz});
        chk("overflow", {63'h0, overflow}, {63'h0, e.ov});
        if (!e.dz && !e.ov) begin
          sa = longint'($signed(e.a)); sb_ = longint'($signed(e.b));
          sq = longint'($signed(quot)); sr = longint'($signed(rem));
          chk("identity", 64'(sq * sb_ + sr), 64'(sa));
          chk("rem_bound", {63'h0, (sr < 0 ? -sr : sr) < (sb_ < 0 ? -sb_ : sb_)}, 64'h1);
        end
      end
    end
  end

  // drives one operation; with noisy set, in_valid stays high with junk operands while busy
  task automatic do_op(input vec_t v, input bit noisy);
    int k;
    sb.push_back(v);
    in_valid = 1'b1; a = v.a; b = v.b;
    k = 0;
    while (!in_ready && k < 200) begin @(posedge clk); #1; k++; end
    chk("accept_wait", {63'h0, in_ready}, 64'h1);
    @(posedge clk); #1;
    if (noisy) begin a = $urandom; b = $urandom; end else in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 200) begin @(posedge clk); #1; k++; end
    in_valid = 1'b0;
    chk("latency", 64'(k), 64'(N + 2));
    if (out_ready) begin
      @(posedge clk); #1;
      chk("post_handshake", {62'h0, in_ready, out_valid}, 64'h2);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return MIN;
      1: return MAX;
      2: return -MAX;
      3: return 32'(1 - 2 * int'($urandom_range(0, 1)));
      4: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t v;
    logic [31:0] hq, hr;
    tbl[0]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0};
    tbl[1]  = '{-32'd7, 32'd2, -32'd3, -32'd1, 1'b0, 1'b0};
    tbl[2]  = '{32'd7, -32'd2, -32'd3, 32'd1, 1'b0, 1'b0};
    tbl[3]  = '{-32'd5, -32'd3, 32'd1, -32'd2, 1'b0, 1'b0};
    tbl[4]  = '{32'd5, 32'd0, 32'hffff_ffff, 32'd5, 1'b1, 1'b0};
    tbl[5]  = '{MIN, 32'hffff_ffff, MIN, 32'd0, 1'b0, 1'b1};
    tbl[6]  = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0};
    tbl[7]  = '{MAX, 32'd1, MAX, 32'd0, 1'b0, 1'b0};
    tbl[8]  = '{MIN, 32'd1, MIN, 32'd0, 1'b0, 1'b0};
    tbl[9]  = '{MIN, MAX, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 1'b0};
    tbl[10] = '{MAX, MIN, 32'd0, MAX, 1'b0, 1'b0};
    tbl[11] = '{32'd0, 32'd0, 32'hffff_ffff, 32'd0, 1'b1, 1'b0};
    tbl[12] = '{-32'd1, MIN, 32'd0, 32'hffff_ffff, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready_valid", {62'h0, in_ready, out_valid}, 64'h2);
    chk("reset_quot_rem", {quot, rem}, 64'h0);
    chk("reset_flags", {62'h0, div_by_zero, overflow}, 64'h0);
    foreach (tbl[i]) do_op(tbl[i], i % 2 == 1);
    // backpressure: result must hold for 5 cycles, handshake on the 6th
    out_ready = 1'b0;
    do_op('{32'd1234, -32'd10, -32'd123, 32'd4, 1'b0, 1'b0}, 1'b0);
    hq = quot; hr = rem;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_ready", {62'h0, out_valid, in_ready}, 64'h2);
      chk("bp_hold", {quot, rem}, {hq, hr});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {62'h0, in_ready, out_valid}, 64'h2);
    chk("bp_keep_result", {quot, rem}, {hq, hr});
    // reset after 10 ITER cycles of 1000/3: the operation is discarded
    in_valid = 1'b1; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_ready_valid", {62'h0, in_ready, out_valid}, 64'h2);
    chk("midreset_quot_rem", {quot, rem}, 64'h0);
    do_op('{32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 1'b0}, 1'b0);
    for (int i = 0; i < 1200; i++) begin
      v = model(pick(), pick());
      do_op(v, i % 7 == 0);
    end
    repeat (40) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
